// File: rtl/mux_sched_pkg.sv
// Shared definitions for the round-robin mux scheduler: datapath sizes,
// scheduler state encoding and the rotate-priority pick function.
package mux_sched_pkg;

    localparam int DW    = 4;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    // Winner is the first set request bit found scanning last+1, last+2,
    // last+3, last+4 (mod NREQ); the previous winner therefore has lowest
    // priority. Returns last when no request is set.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [SEL_W-1:0] last
    );
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        logic             found;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + SEL_W'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Combinational rotate-priority encoder: picks the next requester after
// the last granted one.
module mux_rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] winner
);

    // Rotate-priority selection of the next winner
    always_comb begin
        winner = rr_pick(req, last);
    end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler sharing a 4-input mux between four valid/ready
// requesters. Drives the external mux select and forwards the selected beat
// through a registered valid/ready output stage. A grant is held for at most
// MAX_HOLD beats or until the granted requester drops valid.
// Optional feature: define MUX_RR_SCHED_STATS_EN to add the grant_cnt port
// with per-requester saturating grant counters.
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef MUX_RR_SCHED_STATS_EN
    output logic [31:0]          grant_cnt,
`endif
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [SEL_W-1:0]     sel,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    sched_state_t      state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  last_grant_q, last_grant_d;
    logic [3:0]        beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     out_data_q, out_data_d;

    logic [SEL_W-1:0]  pick_s;
    logic [NREQ-1:0]   req_ready_s;
    logic [DW-1:0]     sel_data_s;
    logic              accept_s;
    logic              any_req_s;

    mux_rr_pick u_pick (
        .req    (req_valid),
        .last   (last_grant_q),
        .winner (pick_s)
    );

    assign any_req_s  = (req_valid != {NREQ{1'b0}});
    assign sel_data_s = req_data[sel_q*DW +: DW];

    // Ready only to the granted requester, and only when the output slot frees up
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (state_q == GRANT) begin
            req_ready_s[sel_q] = !out_valid_q || out_ready;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    assign accept_s = (state_q == GRANT) && req_valid[sel_q] && req_ready_s[sel_q];

    // Grant FSM: arbitrate in IDLE, hold the grant for a bounded burst in GRANT
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    sel_d        = pick_s;
                    last_grant_d = pick_s;
                    beat_cnt_d   = 4'd0;
                    state_d      = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (accept_s) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
                // A dropped valid releases at once; a full burst releases on its last beat
                if (!req_valid[sel_q]) begin
                    state_d = IDLE;
                end else if (accept_s && ((beat_cnt_q + 4'd1) == MAX_HOLD_C)) begin
                    state_d = IDLE;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on accept, empty on downstream take, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data_s;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers; last_grant resets to 3 so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            last_grant_q <= 2'd3;
            beat_cnt_q   <= 4'd0;
            out_valid_q  <= 1'b0;
            out_data_q   <= {DW{1'b0}};
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

`ifdef MUX_RR_SCHED_STATS_EN
    logic [NREQ-1:0][7:0] grant_cnt_q, grant_cnt_d;

    // Count IDLE->GRANT wins per requester, saturating at 255
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if ((state_q == IDLE) && any_req_s && (grant_cnt_q[pick_s] != 8'hFF)) begin
            grant_cnt_d[pick_s] = grant_cnt_q[pick_s] + 8'd1;
        end else begin
            grant_cnt_d = grant_cnt_q;
        end
    end

    // Grant counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= {(NREQ*8){1'b0}};
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

    assign req_ready = req_ready_s;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: per-requester source memories feed a
// scoreboard of expected output beats; directed steps check grant timing,
// order, burst length, backpressure, drop release and reset.
module tb_mux_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  sel;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_ready;
    logic        busy;
`ifdef MUX_RR_SCHED_STATS_EN
    logic [31:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    mux_rr_sched #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MUX_RR_SCHED_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] src_mem [4][2048];
    int         src_rd [4];
    int         src_wr [4];
    logic [3:0] en;
    logic [3:0] sb_q [$];
    int         beats_out;
    int         grant_log [$];
    int         run_log [$];
    int         gap_log [$];
    int         run_len;
    int         idle_len;
    logic       prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (en[i] && (src_rd[i] != src_wr[i])) begin
                req_valid[i]       = 1'b1;
                req_data[4*i +: 4] = src_mem[i][src_rd[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[4*i +: 4] = 4'h0;
            end
        end
    endtask

    task automatic load(input int r, input logic [3:0] d);
        src_mem[r][src_wr[r]] = d;
        src_wr[r]++;
    endtask

    task automatic clear_all();
        sb_q.delete();
        grant_log.delete();
        run_log.delete();
        gap_log.delete();
        for (int i = 0; i < 4; i++) begin
            src_rd[i] = 0;
            src_wr[i] = 0;
        end
        run_len   = 0;
        idle_len  = 0;
        prev_busy = 1'b0;
        beats_out = 0;
    endtask

    // One clock: sample handshakes before the edge, update scoreboard after it
    task automatic cycle();
        logic [3:0] acc_in;
        logic       acc_out;
        logic [3:0] od;
        logic [3:0] e;
        @(negedge clk);
        acc_in  = req_valid & req_ready;
        acc_out = out_valid & out_ready;
        od      = out_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc_in[i]) begin
                sb_q.push_back(src_mem[i][src_rd[i]]);
                src_rd[i]++;
            end
        end
        if (acc_out) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(od), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", 32'(od), 32'(e));
                beats_out++;
            end
        end
        drive_inputs();
        #1;
        if (busy) begin
            if (!prev_busy) begin
                if (grant_log.size() > 0) gap_log.push_back(idle_len);
                grant_log.push_back(int'(sel));
                run_len = 0;
            end
            run_len++;
        end else begin
            if (prev_busy) begin
                run_log.push_back(run_len);
                idle_len = 1;
            end else begin
                idle_len++;
            end
        end
        prev_busy = busy;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        en  = 4'h0;
        drive_inputs();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        rst       = 1'b1;
        en        = 4'h0;
        out_ready = 1'b1;
        req_valid = 4'h0;
        req_data  = 16'h0;
        clear_all();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;

        // Single requester b: grant timing, burst limit, regrant after one bubble
        for (int k = 0; k < 8; k++) load(1, 4'(5 + k));
        en = 4'b0010;
        drive_inputs();
        #1;
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_idle_ready", 32'(req_ready), 32'd0);
        cycle();
        chk("t1_sel", 32'(sel), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_no_out_yet", 32'(out_valid), 32'd0);
        chk("t1_ready", 32'(req_ready), 32'b0010);
        cycle();
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'h5);
        repeat (3) cycle();
        chk("t1_release_after_4", 32'(busy), 32'd0);
        cycle();
        chk("t1_regrant_busy", 32'(busy), 32'd1);
        chk("t1_regrant_sel", 32'(sel), 32'd1);
        repeat (12) cycle();
        chk("t1_beats", 32'(beats_out), 32'd8);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("t1_runs", 32'(run_log.size()), 32'd2);
        chk("t1_gap", 32'(gap_log.size() > 0 ? gap_log[0] : -1), 32'd1);

        // All four valid: order 0,1,2,3,0,..., 4-beat bursts, 1-cycle gaps
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) load(i, 4'(i*4 + k));
        en = 4'b1111;
        drive_inputs();
        repeat (50) cycle();
        chk("t2_grants", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++)
            chk("t2_order", 32'(grant_log[k]), 32'(exp_order[k]));
        for (int k = 0; k < run_log.size(); k++)
            chk("t2_burst_len", 32'(run_log[k]), 32'd4);
        for (int k = 0; k < gap_log.size(); k++)
            chk("t2_gap", 32'(gap_log[k]), 32'd1);
        chk("t2_beats", 32'(beats_out), 32'd32);

        // Backpressure mid-burst: output holds, no ready, nothing lost
        do_reset();
        for (int k = 0; k < 4; k++) load(2, 4'(1 + k));
        en = 4'b0100;
        drive_inputs();
        cycle();
        chk("t3_sel", 32'(sel), 32'd2);
        cycle();
        cycle();
        out_ready = 1'b0;
        #1;
        chk("t3_hold_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_hold_data", 32'(out_data), 32'h2);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        repeat (12) cycle();
        chk("t3_beats", 32'(beats_out), 32'd4);
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // Requester 0 drops after 2 beats; requester 1 gets a fresh burst
        do_reset();
        load(0, 4'h9);
        load(0, 4'hA);
        load(1, 4'hB);
        load(1, 4'hC);
        load(1, 4'hD);
        en = 4'b0011;
        drive_inputs();
        cycle();
        chk("t4_sel0", 32'(sel), 32'd0);
        cycle();
        cycle();
        chk("t4_still_grant", 32'(busy), 32'd1);
        cycle();
        chk("t4_drop_release", 32'(busy), 32'd0);
        cycle();
        chk("t4_next_busy", 32'(busy), 32'd1);
        chk("t4_next_sel", 32'(sel), 32'd1);
        repeat (3) cycle();
        chk("t4_cnt_restart", 32'(busy), 32'd1);
        cycle();
        chk("t4_second_release", 32'(busy), 32'd0);
        repeat (6) cycle();
        chk("t4_beats", 32'(beats_out), 32'd5);

        // Reset during GRANT with a pending output beat
        do_reset();
        for (int k = 0; k < 8; k++) load(3, 4'(8 + k));
        en = 4'b1000;
        drive_inputs();
        cycle();
        chk("t5_sel3", 32'(sel), 32'd3);
        cycle();
        cycle();
        chk("t5_pending", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_sel", 32'(sel), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_ready", 32'(req_ready), 32'd0);
        clear_all();
        load(0, 4'h1);
        load(0, 4'h2);
        load(3, 4'h3);
        load(3, 4'h4);
        en = 4'b1001;
        drive_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        cycle();
        chk("t5_first_winner", 32'(sel), 32'd0);
        chk("t5_first_busy", 32'(busy), 32'd1);
        repeat (12) cycle();
        chk("t5_beats", 32'(beats_out), 32'd4);

`ifdef MUX_RR_SCHED_STATS_EN
        // Saturating grant counter on requester 2
        do_reset();
        chk("st_reset", grant_cnt, 32'd0);
        for (int k = 0; k < 1300; k++) load(2, 4'(k));
        en = 4'b0100;
        drive_inputs();
        for (int c = 0; c < 2000 && grant_log.size() < 300; c++) cycle();
        chk("st_grants", 32'(grant_log.size()), 32'd300);
        chk("st_sat", 32'(grant_cnt[23:16]), 32'd255);
        chk("st_others", {8'h0, grant_cnt[31:24], grant_cnt[15:0]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
